ttt_move_generator: RTL and testbench
=====================================

# ttt_move_generator

Computer-side opponent for the tic-tac-toe game datapath. On a request it snapshots the 9-cell board, searches for a move (complete own line, else block the player's line, else centre, else corner, else edge) with a multi-cycle line-scan FSM, and returns the chosen cell index with a one-cycle `done` pulse. `move_pos` drives the game's computer-position input, and `done & ~no_move` drives its computer-play confirm.

## Interface
- `COMP_MARK`, 2'b10: cell code of a computer-owned cell.
- `PLAYER_MARK`, 2'b01: cell code of a player-owned cell.
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  move request; sampled only in IDLE.
- `board`  in  18  cell i (0..8, row-major) is `board[2i+1:2i]`. 2'b00 means empty; 2'b11 is occupied and matches no mark.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  registered one-cycle pulse when a result is ready.
- `move_pos`  out  4  chosen cell 0..8; held until the next `done`.
- `no_move`  out  1  registered with `done`; high when the board has no empty cell; held until the next `done`.

## Operation
- States: IDLE, SCAN_WIN, SCAN_BLOCK, PICK, DONE. Line counter `line_idx` is 3 bits.
- Line table, indices 0..7: (0,1,2), (3,4,5), (6,7,8), (0,3,6), (1,4,7), (2,5,8), (0,4,8), (2,4,6).
- IDLE + `start`=1:
  - `board` is copied into the snapshot register.
  - `line_idx`←0, state→SCAN_WIN.
  - `start` is ignored in all other states.
- SCAN_WIN evaluates one line per cycle against the snapshot.
  - Hit: exactly two cells == COMP_MARK and the third == 2'b00.
  - On a hit: `move_pos`←the empty cell's index, `no_move`←0, state→DONE.
  - No hit and `line_idx`==7: `line_idx`←0, state→SCAN_BLOCK.
  - Otherwise `line_idx`++.
- SCAN_BLOCK: identical to SCAN_WIN, using PLAYER_MARK. After line 7 with no hit, state→PICK.
- PICK, single cycle. First empty cell in priority order 4, 0, 2, 6, 8, 1, 3, 5, 7:
  - Found: `move_pos`←that cell, `no_move`←0.
  - None found: `no_move`←1 and `move_pos` keeps its previous value.
  - State→DONE.
- DONE: `done`=1 for exactly this cycle; state→IDLE.
- Priority is fixed:
  - A win beats a block.
  - Among several hits, the lowest line index wins.
- The snapshot isolates the search: changes to `board` after the sampling edge do not affect the result.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `move_pos`=4'd0, `no_move`=0, `line_idx`=0, snapshot=18'd0.
- Let edge E0 be the edge that samples `start`.
- SCAN_WIN evaluates line k at edge E(k+1), k = 0..7.
- SCAN_BLOCK evaluates line k at edge E(9+k).
- PICK resolves at edge E17.
- `done` is high in the cycle following the resolving edge, and `move_pos`/`no_move` are valid in that same cycle.
- Latency:
  - Minimum: win on line 0, `done` after E1.
  - Maximum: PICK, `done` after E17.
- `busy` rises after E0 and falls at the edge that ends DONE.
- A new `start` can be accepted on the edge that returns to IDLE + 1 cycle, i.e. the first cycle in which IDLE is observed.
- Reset asserted mid-scan: immediate return to IDLE with all reset values. No `done` is produced for the aborted request.
- `start` held high continuously: a new request is accepted each time IDLE is reached. It has no effect while `busy`.

## Test plan
- Win on line 0:
  - Stimulus: cells 0,1 = 2'b10, all others empty; pulse `start`.
  - Required: `done` after E1, `move_pos`=2, `no_move`=0.
- Block on line 1:
  - Stimulus: cells 3,4 = 2'b01, cell 0 = 2'b10, rest empty.
  - Required: `done` after E10, `move_pos`=5.
- Win priority over block:
  - Stimulus: cells 6,7 = 2'b10, cells 0,1 = 2'b01, rest empty.
  - Required: `move_pos`=8 (line 2 in the win scan), `done` after E3.
- Fallback selection:
  - Empty board: `move_pos`=4 after E17.
  - Only cell 4 occupied (2'b01): `move_pos`=0.
  - Full draw board with no line: `no_move`=1 and `move_pos` unchanged from the previous result.
- Snapshot isolation and abort:
  - Change `board` at E2 of an empty-board request: the result is still 4.
  - Assert `reset` at E5 of a scan: `busy`=0, `done` never pulses, and all outputs return to 0.
- Start while busy:
  - Stimulus: pulse `start` at E3 of a running scan.
  - Required: ignored; exactly one `done` pulse for the original request.

Source files
------------

// File: rtl/ttt_move_generator.sv
// Computer opponent for the tic-tac-toe datapath: scans the eight lines for a
// winning move, then a blocking move, then falls back to centre/corner/edge.
module ttt_move_generator (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] board,
  output logic        busy,
  output logic        done,
  output logic [3:0]  move_pos,
  output logic        no_move
);

  localparam logic [1:0] COMP_MARK   = 2'b10;
  localparam logic [1:0] PLAYER_MARK = 2'b01;
  localparam logic [1:0] EMPTY_CELL  = 2'b00;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SCAN_WIN   = 3'd1,
    SCAN_BLOCK = 3'd2,
    PICK       = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  line_idx_q, line_idx_d;
  logic [17:0] snap_q, snap_d;
  logic [3:0]  move_pos_q, move_pos_d;
  logic        no_move_q, no_move_d;
  logic        done_q, done_d;

  // Cell indices of each line, packed {first, second, third}.
  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    logic [11:0] cells;
    case (idx)
      3'd0:    cells = {4'd0, 4'd1, 4'd2};
      3'd1:    cells = {4'd3, 4'd4, 4'd5};
      3'd2:    cells = {4'd6, 4'd7, 4'd8};
      3'd3:    cells = {4'd0, 4'd3, 4'd6};
      3'd4:    cells = {4'd1, 4'd4, 4'd7};
      3'd5:    cells = {4'd2, 4'd5, 4'd8};
      3'd6:    cells = {4'd0, 4'd4, 4'd8};
      3'd7:    cells = {4'd2, 4'd4, 4'd6};
      default: cells = {4'd0, 4'd1, 4'd2};
    endcase
    return cells;
  endfunction

  function automatic logic [1:0] cell_of(input logic [17:0] snap, input logic [3:0] pos);
    return snap[2*int'(pos) +: 2];
  endfunction

  // Fallback order: centre, corners, then edges.
  function automatic logic [3:0] prio_cell(input int rank);
    logic [3:0] pos;
    case (rank)
      0:       pos = 4'd4;
      1:       pos = 4'd0;
      2:       pos = 4'd2;
      3:       pos = 4'd6;
      4:       pos = 4'd8;
      5:       pos = 4'd1;
      6:       pos = 4'd3;
      7:       pos = 4'd5;
      8:       pos = 4'd7;
      default: pos = 4'd4;
    endcase
    return pos;
  endfunction

  // Returns {found, cell} for the highest-priority empty cell.
  function automatic logic [4:0] pick_cell(input logic [17:0] snap);
    logic [4:0] res;
    res = 5'd0;
    for (int r = 8; r >= 0; r--) begin
      if (cell_of(snap, prio_cell(r)) == EMPTY_CELL) begin
        res = {1'b1, prio_cell(r)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [11:0] cells_s;
  logic [3:0]  c0_s, c1_s, c2_s;
  logic [1:0]  m0_s, m1_s, m2_s, mark_s;
  logic        hit_s;
  logic [3:0]  hit_pos_s;
  logic [4:0]  pick_s;

  // Next-state, line evaluation and result capture.
  always_comb begin
    state_d    = state_q;
    line_idx_d = line_idx_q;
    snap_d     = snap_q;
    move_pos_d = move_pos_q;
    no_move_d  = no_move_q;

    cells_s = line_cells(line_idx_q);
    c0_s    = cells_s[11:8];
    c1_s    = cells_s[7:4];
    c2_s    = cells_s[3:0];
    m0_s    = cell_of(snap_q, c0_s);
    m1_s    = cell_of(snap_q, c1_s);
    m2_s    = cell_of(snap_q, c2_s);
    mark_s  = (state_q == SCAN_WIN) ? COMP_MARK : PLAYER_MARK;
    pick_s  = pick_cell(snap_q);

    hit_s     = 1'b0;
    hit_pos_s = 4'd0;
    if (m0_s == mark_s && m1_s == mark_s && m2_s == EMPTY_CELL) begin
      hit_s     = 1'b1;
      hit_pos_s = c2_s;
    end else if (m0_s == mark_s && m2_s == mark_s && m1_s == EMPTY_CELL) begin
      hit_s     = 1'b1;
      hit_pos_s = c1_s;
    end else if (m1_s == mark_s && m2_s == mark_s && m0_s == EMPTY_CELL) begin
      hit_s     = 1'b1;
      hit_pos_s = c0_s;
    end else begin
      hit_s     = 1'b0;
      hit_pos_s = 4'd0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d     = board;
          line_idx_d = 3'd0;
          state_d    = SCAN_WIN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN_WIN, SCAN_BLOCK: begin
        if (hit_s) begin
          move_pos_d = hit_pos_s;
          no_move_d  = 1'b0;
          state_d    = DONE;
        end else if (line_idx_q == 3'd7) begin
          line_idx_d = 3'd0;
          state_d    = (state_q == SCAN_WIN) ? SCAN_BLOCK : PICK;
        end else begin
          line_idx_d = line_idx_q + 3'd1;
        end
      end
      PICK: begin
        if (pick_s[4]) begin
          move_pos_d = pick_s[3:0];
          no_move_d  = 1'b0;
        end else begin
          no_move_d  = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
  end

  // State and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      line_idx_q <= 3'd0;
      snap_q     <= 18'd0;
      move_pos_q <= 4'd0;
      no_move_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_idx_q <= line_idx_d;
      snap_q     <= snap_d;
      move_pos_q <= move_pos_d;
      no_move_q  <= no_move_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign move_pos = move_pos_q;
  assign no_move  = no_move_q;

endmodule

// File: tb/tb_ttt_move_generator.sv
// Scoreboard bench for ttt_move_generator: requests push expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_ttt_move_generator;

  logic        clock;
  logic        reset;
  logic        start;
  logic [17:0] board;
  logic        busy;
  logic        done;
  logic [3:0]  move_pos;
  logic        no_move;

  ttt_move_generator dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .board    (board),
    .busy     (busy),
    .done     (done),
    .move_pos (move_pos),
    .no_move  (no_move)
  );

  typedef struct {
    logic [3:0] pos;
    logic       nm;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failures = 0;
  int   cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL unexpected_done: actual done=1 required done=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_latency"}, cyc, e.cyc);
        check({e.name, "_move_pos"}, int'(move_pos), int'(e.pos));
        check({e.name, "_no_move"}, int'(no_move), int'(e.nm));
      end
    end
  end

  function automatic logic [17:0] put(input logic [17:0] b, input int idx, input logic [1:0] m);
    logic [17:0] r;
    r = b;
    r[2*idx +: 2] = m;
    return r;
  endfunction

  // ev_kind: 0 none, 1 change board at ev_cycle, 2 pulse start at ev_cycle.
  task automatic run_req(input string name, input logic [17:0] b, input logic [3:0] pos,
                         input logic nm, input int lat, input int ev_kind,
                         input int ev_cycle, input logic [17:0] alt_b);
    int e0;
    int waited;
    waited = 0;
    @(negedge clock);
    while ((busy || done) && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    board = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    e0 = cyc;
    sb.push_back('{pos: pos, nm: nm, cyc: e0 + lat, name: name});
    @(negedge clock);
    start = 1'b0;
    if (ev_kind != 0) begin
      repeat (ev_cycle - 1) @(posedge clock);
      @(negedge clock);
      if (ev_kind == 1) begin
        board = alt_b;
      end else begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      tests++;
      failures++;
      $display("FAIL %s_timeout: actual no done required done within 40 cycles", name);
      sb.delete();
    end
  endtask

  logic [17:0] b_win0, b_blk1, b_draw, b_c4, b_prio, b_diag, b_alt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    board = 18'd0;

    b_win0 = put(put(18'd0, 0, 2'b10), 1, 2'b10);
    b_blk1 = put(put(put(18'd0, 3, 2'b01), 4, 2'b01), 0, 2'b10);
    b_draw = 18'd0;
    b_draw = put(b_draw, 0, 2'b10); b_draw = put(b_draw, 1, 2'b01); b_draw = put(b_draw, 2, 2'b10);
    b_draw = put(b_draw, 3, 2'b10); b_draw = put(b_draw, 4, 2'b01); b_draw = put(b_draw, 5, 2'b01);
    b_draw = put(b_draw, 6, 2'b01); b_draw = put(b_draw, 7, 2'b10); b_draw = put(b_draw, 8, 2'b10);
    b_c4   = put(18'd0, 4, 2'b01);
    b_prio = put(put(put(put(18'd0, 6, 2'b10), 7, 2'b10), 0, 2'b01), 1, 2'b01);
    b_diag = put(put(18'd0, 4, 2'b10), 8, 2'b10);
    b_alt  = b_win0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_move_pos", int'(move_pos), 0);
    check("reset_no_move", int'(no_move), 0);
    @(negedge clock);
    reset = 1'b0;

    run_req("win_line0", b_win0, 4'd2, 1'b0, 1, 0, 0, 18'd0);
    run_req("block_line1", b_blk1, 4'd5, 1'b0, 10, 0, 0, 18'd0);
    run_req("draw_no_move", b_draw, 4'd5, 1'b1, 17, 0, 0, 18'd0);

    // Abort a scan with reset: outputs clear and no done follows.
    @(negedge clock);
    board = 18'd0;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_move_pos", int'(move_pos), 0);
    check("abort_no_move", int'(no_move), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(posedge clock);

    run_req("empty_center", 18'd0, 4'd4, 1'b0, 17, 0, 0, 18'd0);
    run_req("center_taken", b_c4, 4'd0, 1'b0, 17, 0, 0, 18'd0);
    run_req("win_over_block", b_prio, 4'd8, 1'b0, 3, 0, 0, 18'd0);
    run_req("snapshot", 18'd0, 4'd4, 1'b0, 17, 1, 2, b_alt);
    run_req("start_busy", b_diag, 4'd0, 1'b0, 7, 2, 3, 18'd0);

    repeat (25) @(posedge clock);
    #1;
    check("idle_after_all", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
